ddr_app_arbiter: RTL
====================

Name: ddr_app_arbiter

Overview:
- Shares the single DDR controller app interface (command, write-data and read-data channels) between two requesters.
- Port W is the DMA write path: bitstream bytes packed to 256 bits and stored to DDR.
- Port R is the configuration prefetch path: reads DDR and feeds the ICAP config buffer.
- Issues whole commands, tracks outstanding reads, routes read data back to port R, and arbitrates round-robin.

Parameters:
- ADDR_W, 27, DDR app address width.
- DATA_W, 256, app data width.
- MAX_OUTSTANDING, 8, maximum read commands in flight. Counter width is clog2(MAX_OUTSTANDING+1).

Ports:
- i_clk  in  1  system clock (200 MHz domain)
- i_rst  in  1  asynchronous, active-low reset
- i_wr_req  in  1  port W request; level, held until o_wr_ack
- i_wr_addr  in  ADDR_W  port W address; stable while i_wr_req
- i_wr_data  in  DATA_W  port W data; stable while i_wr_req
- o_wr_ack  out  1  one-cycle pulse: write command and data both accepted
- i_rd_req  in  1  port R request; level, held until o_rd_ack
- i_rd_addr  in  ADDR_W  port R address; stable while i_rd_req
- o_rd_ack  out  1  one-cycle pulse: read command accepted
- o_rd_data  out  DATA_W  read data to port R
- o_rd_data_valid  out  1  read data valid
- app_en  out  1  controller command enable
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_addr  out  ADDR_W  command address
- app_rdy  in  1  command accepted when high with app_en
- app_wdf_wren  out  1  write-data enable
- app_wdf_data  out  DATA_W  write data
- app_wdf_end  out  1  equals app_wdf_wren (single-beat bursts)
- app_wdf_rdy  in  1  write data accepted when high with app_wdf_wren
- app_rd_data  in  DATA_W  read data from controller
- app_rd_data_valid  in  1  read data valid
- o_busy  out  1  FSM not IDLE, or outstanding count != 0

Behaviour:
- Reset (i_rst low, asynchronous):
  - FSM to IDLE; outstanding count 0; last-grant = R, so W wins the first tie.
  - app_en, app_wdf_wren, app_wdf_end, o_wr_ack, o_rd_ack, o_rd_data_valid, o_busy = 0.
  - app_cmd, app_addr, app_wdf_data = 0.
  - Reset mid-transaction abandons it without an ack. Requesters are reset by the same i_rst.
- FSM states: IDLE, WR, RD.
- IDLE:
  - Eligible requesters: W if i_wr_req; R if i_rd_req and count < MAX_OUTSTANDING.
  - One eligible: grant it. Both eligible: grant the one not in last-grant.
  - On grant, register app_addr/app_cmd (and app_wdf_data for W) and move to WR or RD. The registered outputs appear in the next cycle.
  - No eligible requester: stay in IDLE.
- WR:
  - app_en=1, app_cmd=000, app_wdf_wren=app_wdf_end=1 on entry.
  - Command and data handshakes are independent:
    - app_en drops in the cycle after app_rdy is seen.
    - app_wdf_wren drops in the cycle after app_wdf_rdy is seen.
    - Sticky flags cmd_done and data_done record each acceptance.
  - o_wr_ack is combinational and pulses in the cycle the second of the two acceptances occurs, including when both occur together. Next state is IDLE; last-grant = W.
- RD:
  - app_en=1, app_cmd=001.
  - On app_rdy: o_rd_ack pulses combinationally that cycle, count increments, next state IDLE, last-grant = R.
- Minimum spacing: one IDLE cycle between transactions, so at most one command per 2 cycles.
- Read return path:
  - o_rd_data = app_rd_data and o_rd_data_valid = app_rd_data_valid, registered (1-cycle latency).
  - Each app_rd_data_valid decrements count.
  - Increment and decrement in the same cycle leave count unchanged.
  - A valid with count == 0 is a protocol error: count holds at 0 and a simulation assertion fires.
  - Port R must always accept data; there is no backpressure.
- Ordering: the controller is in-order. Read-after-write hazards to the same address are the requesters' responsibility.
- app_rdy or app_wdf_rdy arriving while the corresponding enable is low is ignored.
- A requester that drops its request while granted is not supported (assertion).

Decomposition:
- Shared package (ddr_pkg): CMD_WRITE=3'b000, CMD_READ=3'b001, ADDR_W, DATA_W, FSM state enum.
- One sub-module, rd_credit_counter: an up/down saturating outstanding counter with full/empty flags, reused by the icap_controller buffer logic.

Test Plan:
- Single write, addr 27'h100, data all 0xA5, app_rdy and app_wdf_rdy held 1 -> app_en and app_wdf_wren high for exactly 1 cycle; o_wr_ack pulses in that cycle; o_busy returns to 0.
- Write with app_wdf_rdy stalled 3 cycles, app_rdy immediate -> app_en high 1 cycle; app_wdf_wren high 4 cycles; o_wr_ack pulses in the 4th cycle only.
- Both requests held continuously, controller always ready -> grants alternate W, R, W, R, one command every 2 cycles, W first after reset.
- 9 back-to-back reads with MAX_OUTSTANDING=8 and no read data returned -> 8 o_rd_ack pulses; the 9th waits in IDLE; one app_rd_data_valid releases it on the following cycle.
- Read data 0x1234 (zero-extended) returned in the same cycle a new read command is accepted -> count unchanged; o_rd_data=0x1234 with valid one cycle later.
- i_rst pulsed low during WR with app_wdf_rdy=0 -> all outputs 0 immediately (asynchronously); no o_wr_ack; after release, a pending i_wr_req is re-granted from IDLE.

Source files
------------

// File: rtl/ddr_app_arbiter_pkg.sv
// Shared definitions for the DDR app-interface arbiter: widths, command codes, FSM state.
package ddr_app_arbiter_pkg;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 256;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD
  } arb_state_e;

  typedef enum logic {
    GRANT_W,
    GRANT_R
  } grant_e;

endpackage

// File: rtl/ddr_app_arbiter_if.sv
// DDR controller app interface: command, write-data and read-data channels.
interface ddr_app_arbiter_if #(
  parameter int ADDR_W = ddr_app_arbiter_pkg::ADDR_W,
  parameter int DATA_W = ddr_app_arbiter_pkg::DATA_W
) ();

  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_rdy;
  logic              app_wdf_wren;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  // Arbiter side: drives commands and write data, receives read data.
  modport master (
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  // Controller side.
  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

endinterface

// File: rtl/ddr_app_arbiter_rd_credit_counter.sv
// Up/down saturating outstanding-read counter with full/empty flags.
module rd_credit_counter #(
  parameter  int MAX = 8,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic do_inc;
  logic do_dec;

  // Saturate at both ends; a simultaneous increment and decrement cancel.
  always_comb begin
    o_full  = (o_count == MAX_C);
    o_empty = (o_count == '0);
    do_inc  = i_inc && !o_full;
    do_dec  = i_dec && !o_empty;
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_count <= '0;
    end else begin
      case ({do_inc, do_dec})
        2'b10:   o_count <= o_count + CW'(1);
        2'b01:   o_count <= o_count - CW'(1);
        default: o_count <= o_count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_app_arbiter.sv
// Shares one DDR app interface between a DMA write port (W) and a config prefetch read port (R).
module ddr_app_arbiter #(
  parameter int ADDR_W          = ddr_app_arbiter_pkg::ADDR_W,
  parameter int DATA_W          = ddr_app_arbiter_pkg::DATA_W,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_req,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0]  i_wr_data,
  output logic               o_wr_ack,
  input  logic               i_rd_req,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic               o_rd_ack,
  output logic [DATA_W-1:0]  o_rd_data,
  output logic               o_rd_data_valid,
  ddr_app_arbiter_if.master  app,
  output logic               o_busy
);

  import ddr_app_arbiter_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e       state;
  grant_e           last_grant;
  logic             cmd_done;
  logic             data_done;
  logic             cmd_acc;
  logic             data_acc;
  logic             wr_done;
  logic             rd_acc;
  logic             w_elig;
  logic             r_elig;
  logic             grant_w;
  logic             grant_r;
  logic [CNT_W-1:0] rd_count;
  logic             cnt_full;
  logic             cnt_empty;

  // Handshake decode and round-robin grant selection.
  always_comb begin
    cmd_acc  = app.app_en && app.app_rdy;
    data_acc = app.app_wdf_wren && app.app_wdf_rdy;
    // Write completes when the later of the two acceptances lands (or both at once).
    wr_done  = (state == ST_WR) && (cmd_done || cmd_acc) && (data_done || data_acc);
    rd_acc   = (state == ST_RD) && cmd_acc;
    w_elig   = i_wr_req;
    r_elig   = i_rd_req && !cnt_full;
    grant_w  = (state == ST_IDLE) && w_elig && (!r_elig || (last_grant == GRANT_R));
    grant_r  = (state == ST_IDLE) && r_elig && !grant_w;
    o_wr_ack = wr_done;
    o_rd_ack = rd_acc;
    o_busy   = (state != ST_IDLE) || !cnt_empty;
  end

  assign app.app_wdf_end = app.app_wdf_wren;

  // Command FSM with registered app-side outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state            <= ST_IDLE;
      last_grant       <= GRANT_R;
      cmd_done         <= 1'b0;
      data_done        <= 1'b0;
      app.app_en       <= 1'b0;
      app.app_cmd      <= '0;
      app.app_addr     <= '0;
      app.app_wdf_wren <= 1'b0;
      app.app_wdf_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_w) begin
            state            <= ST_WR;
            cmd_done         <= 1'b0;
            data_done        <= 1'b0;
            app.app_en       <= 1'b1;
            app.app_cmd      <= CMD_WRITE;
            app.app_addr     <= i_wr_addr;
            app.app_wdf_wren <= 1'b1;
            app.app_wdf_data <= i_wr_data;
          end else if (grant_r) begin
            state        <= ST_RD;
            app.app_en   <= 1'b1;
            app.app_cmd  <= CMD_READ;
            app.app_addr <= i_rd_addr;
          end
        end
        ST_WR: begin
          if (cmd_acc) begin
            app.app_en <= 1'b0;
            cmd_done   <= 1'b1;
          end
          if (data_acc) begin
            app.app_wdf_wren <= 1'b0;
            data_done        <= 1'b1;
          end
          if (wr_done) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_W;
          end
        end
        ST_RD: begin
          if (rd_acc) begin
            app.app_en <= 1'b0;
            state      <= ST_IDLE;
            last_grant <= GRANT_R;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read return path: one-cycle registered pass-through, no backpressure.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rd_data       <= '0;
      o_rd_data_valid <= 1'b0;
    end else begin
      o_rd_data       <= app.app_rd_data;
      o_rd_data_valid <= app.app_rd_data_valid;
    end
  end

  rd_credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_credit (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (rd_acc),
    .i_dec   (app.app_rd_data_valid),
    .o_count (rd_count),
    .o_full  (cnt_full),
    .o_empty (cnt_empty)
  );

  a_rd_underflow: assert property (@(posedge i_clk) disable iff (!i_rst)
    app.app_rd_data_valid |-> (rd_count != '0));

  a_wr_req_held: assert property (@(posedge i_clk) disable iff (!i_rst)
    (state == ST_WR) |-> i_wr_req);

  a_rd_req_held: assert property (@(posedge i_clk) disable iff (!i_rst)
    (state == ST_RD) |-> i_rd_req);

endmodule
